alu_issue_queue: RTL and testbench

Operand issue stage placed directly upstream of the 32-bit ALU. It accepts decoded ALU operations from decode through a valid/ready handshake and buffers them in a small in-order queue. While an operation waits, it snoops the result-forwarding bus and patches stale register operands. It presents the head entry as A, B, ALUControl and destination register to the ALU input.

---
 rtl/alu_issue_queue.sv | 100 ++++++++++
 tb/tb_alu_issue_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order operand queue ahead of the ALU with forwarding-bus snoop on stored operands
module alu_issue_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_alu_ctrl,
  input  logic        fwd_valid,
  input  logic [4:0]  fwd_rd,
  input  logic [31:0] fwd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  output logic [4:0]  alu_rd
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0] a_q [DEPTH], a_d [DEPTH], b_q [DEPTH], b_d [DEPTH];
  logic [4:0]  rs1_q [DEPTH], rs1_d [DEPTH], rs2_q [DEPTH], rs2_d [DEPTH], rd_q [DEPTH], rd_d [DEPTH];
  logic [2:0]  ctrl_q [DEPTH], ctrl_d [DEPTH];
  logic        breg_q [DEPTH], breg_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic fwd_hit, push, pop;
  assign in_ready  = cnt_q != FULL;
  assign out_valid = cnt_q != '0;
  assign fwd_hit   = fwd_valid && fwd_rd != 5'd0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign alu_a     = out_valid ? a_q[rp_q] : 32'd0;
  assign alu_b     = out_valid ? b_q[rp_q] : 32'd0;
  assign alu_ctrl  = out_valid ? ctrl_q[rp_q] : 3'd0;
  assign alu_rd    = out_valid ? rd_q[rp_q] : 5'd0;
  // snoop-patch live entries, then write the new entry (forwarded value wins over the regfile read)
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    rd_d = rd_q;
    ctrl_d = ctrl_q;
    breg_d = breg_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (fwd_hit && ({1'b0, AW'(i) - rp_q} < cnt_q)) begin
        a_d[i] = rs1_q[i] == fwd_rd ? fwd_data : a_q[i];
        b_d[i] = breg_q[i] && rs2_q[i] == fwd_rd ? fwd_data : b_q[i];
      end
    end
    if (push) begin
      a_d[wp_q]    = fwd_hit && in_rs1 == fwd_rd ? fwd_data : in_rs1_val;
      b_d[wp_q]    = in_use_imm ? in_imm : fwd_hit && in_rs2 == fwd_rd ? fwd_data : in_rs2_val;
      rs1_d[wp_q]  = in_rs1;
      rs2_d[wp_q]  = in_rs2;
      breg_d[wp_q] = !in_use_imm;
      ctrl_d[wp_q] = in_alu_ctrl;
      rd_d[wp_q]   = in_rd;
    end
    wp_d  = flush ? '0 : wp_q + AW'(push);
    rp_d  = flush ? '0 : rp_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // state registers; reset empties the queue and clears every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '{default: '0};
      b_q    <= '{default: '0};
      rs1_q  <= '{default: '0};
      rs2_q  <= '{default: '0};
      rd_q   <= '{default: '0};
      ctrl_q <= '{default: '0};
      breg_q <= '{default: '0};
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
      breg_q <= breg_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed checks of handshake, ordering, forwarding, flush and async reset
module tb_alu_issue_queue;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_ready, in_use_imm = 0;
  logic [4:0] in_rs1 = 0, in_rs2 = 0, in_rd = 0, fwd_rd = 0, alu_rd;
  logic [31:0] in_rs1_val = 0, in_rs2_val = 0, in_imm = 0, fwd_data = 0, alu_a, alu_b;
  logic [2:0] in_alu_ctrl = 0, alu_ctrl;
  logic fwd_valid = 0, out_valid, out_ready = 0;
  int vectors = 0, miscompares = 0;

  alu_issue_queue #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_alu_ctrl(in_alu_ctrl),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_rd(alu_rd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [31:0] v1, input logic [4:0] rs2,
                       input logic [31:0] v2, input logic ui, input logic [31:0] imm,
                       input logic [2:0] ctrl, input logic [4:0] rd);
    in_valid = 1; in_rs1 = rs1; in_rs1_val = v1; in_rs2 = rs2; in_rs2_val = v2;
    in_use_imm = ui; in_imm = imm; in_alu_ctrl = ctrl; in_rd = rd;
  endtask

  task automatic pop_one;
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
    chk("rst_alu_rd", 32'(alu_rd), 0);
    tick;
    rst_n = 1;
    tick;
    // single op, one-cycle latency, popped next edge
    out_ready = 1;
    offer(1, 5, 2, 7, 0, 0, 3'b000, 3);
    tick;
    in_valid = 0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_a", alu_a, 5);
    chk("t1_b", alu_b, 7);
    chk("t1_ctrl", 32'(alu_ctrl), 0);
    chk("t1_rd", 32'(alu_rd), 3);
    tick;
    chk("t1_drain_valid", 32'(out_valid), 0);
    chk("t1_drain_a", alu_a, 0);
    // backpressure and in-order drain with DEPTH=2
    out_ready = 0;
    offer(1, 10, 2, 0, 0, 0, 3'd1, 1);
    tick;
    chk("t2_ready1", 32'(in_ready), 1);
    offer(1, 20, 2, 0, 0, 0, 3'd2, 2);
    tick;
    chk("t2_full_ready", 32'(in_ready), 0);
    offer(1, 30, 2, 0, 0, 0, 3'd3, 4);
    tick;
    chk("t2_held_ready", 32'(in_ready), 0);
    chk("t2_head_stable", alu_a, 10);
    chk("t2_head_rd", 32'(alu_rd), 1);
    out_ready = 1;
    tick;
    chk("t2_pop1_a", alu_a, 20);
    chk("t2_pop1_rd", 32'(alu_rd), 2);
    chk("t2_pop1_ready", 32'(in_ready), 1);
    tick;
    in_valid = 0;
    chk("t2_pop2_a", alu_a, 30);
    chk("t2_pop2_ctrl", 32'(alu_ctrl), 3);
    chk("t2_pop2_rd", 32'(alu_rd), 4);
    tick;
    chk("t2_empty", 32'(out_valid), 0);
    // snoop on stored head
    out_ready = 0;
    offer(4, 1, 9, 2, 0, 0, 0, 5);
    tick;
    in_valid = 0;
    fwd_valid = 1; fwd_rd = 4; fwd_data = 32'h99;
    chk("t3_pre_a", alu_a, 1);
    tick;
    chk("t3_snoop_a", alu_a, 32'h99);
    chk("t3_snoop_b", alu_b, 2);
    fwd_rd = 0; fwd_data = 32'h55;
    tick;
    chk("t3_x0_a", alu_a, 32'h99);
    fwd_valid = 0;
    pop_one;
    offer(0, 7, 9, 2, 0, 0, 0, 5);
    tick;
    in_valid = 0;
    fwd_valid = 1; fwd_rd = 0; fwd_data = 32'h55;
    tick;
    fwd_valid = 0;
    chk("t3_rs1_x0_a", alu_a, 7);
    pop_one;
    chk("t3_empty", 32'(out_valid), 0);
    // enqueue-time forwarding: immediate is never patched
    offer(1, 11, 6, 3, 1, 32'hFFFF_FFF0, 0, 7);
    fwd_valid = 1; fwd_rd = 6; fwd_data = 32'hABC;
    tick;
    in_valid = 0; fwd_valid = 0;
    chk("t4_imm_b", alu_b, 32'hFFFF_FFF0);
    chk("t4_imm_a", alu_a, 11);
    pop_one;
    offer(6, 11, 6, 3, 0, 32'hFFFF_FFF0, 0, 7);
    fwd_valid = 1;
    tick;
    in_valid = 0; fwd_valid = 0;
    chk("t4_reg_b", alu_b, 32'hABC);
    chk("t4_reg_a", alu_a, 32'hABC);
    pop_one;
    // snoop reaches the second entry; stored immediate survives a matching rs2
    offer(8, 1, 3, 0, 0, 0, 0, 1);
    tick;
    offer(5, 2, 8, 9, 1, 32'h44, 0, 2);
    tick;
    in_valid = 0;
    fwd_valid = 1; fwd_rd = 8; fwd_data = 32'h77;
    tick;
    fwd_valid = 0;
    chk("t5_head_a", alu_a, 32'h77);
    pop_one;
    chk("t5_second_a", alu_a, 2);
    chk("t5_second_b", alu_b, 32'h44);
    fwd_valid = 1; fwd_rd = 5; fwd_data = 32'h66;
    tick;
    fwd_valid = 0;
    chk("t5_second_snoop_a", alu_a, 32'h66);
    pop_one;
    // flush beats simultaneous push and pop
    offer(1, 40, 2, 0, 0, 0, 0, 1);
    tick;
    offer(1, 41, 2, 0, 0, 0, 0, 2);
    tick;
    chk("t6_full", 32'(in_ready), 0);
    offer(1, 42, 2, 0, 0, 0, 0, 3);
    flush = 1; out_ready = 1;
    tick;
    flush = 0; in_valid = 0; out_ready = 0;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_ready", 32'(in_ready), 1);
    tick;
    chk("t6_absent", 32'(out_valid), 0);
    // asynchronous reset mid-cycle
    offer(1, 50, 2, 51, 0, 0, 3'd5, 6);
    tick;
    offer(1, 52, 2, 53, 0, 0, 3'd6, 7);
    tick;
    in_valid = 0;
    chk("t7_pre_valid", 32'(out_valid), 1);
    #2;
    rst_n = 0;
    #1;
    chk("t7_async_valid", 32'(out_valid), 0);
    chk("t7_async_a", alu_a, 0);
    chk("t7_async_b", alu_b, 0);
    chk("t7_async_ctrl", 32'(alu_ctrl), 0);
    chk("t7_async_rd", 32'(alu_rd), 0);
    chk("t7_async_ready", 32'(in_ready), 1);
    tick;
    rst_n = 1;
    tick;
    chk("t7_no_replay", 32'(out_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
